// File: rtl/ld_cell_sched_if.sv
// A2D conversion handshake between the load-cell scheduler and the shared A2D/SPI block.
// strt_cnv is a one-cycle request with chnl held until done; cnv_cmplt is a one-cycle done pulse, res valid with it.
interface ld_cell_sched_if;
  logic        strt_cnv;
  logic [2:0]  chnl;
  logic        cnv_cmplt;
  logic [11:0] res;

  modport master (output strt_cnv, output chnl, input cnv_cmplt, input res);
  modport slave  (input strt_cnv, input chnl, output cnv_cmplt, output res);
endinterface

// File: rtl/ld_cell_sched.sv
// Round-robin A2D sequencer for left/right load cells and battery, rider/balance flags and settle timer.
// Optional load-cell IIR smoothing is enabled by defining LD_CELL_FILTER_EN.
module ld_cell_sched #(
  parameter int          SAMPLE_PERIOD = 1_000_000,
  parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
  parameter logic [11:0] HYSTERESIS    = 12'h040,
  parameter int          TMR_FULL_CNT  = 65_000_000,
  parameter int          CNV_TIMEOUT   = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  ld_cell_sched_if.master        a2d,
  input  logic                   i_clr_tmr,
  output logic [11:0]            o_lft_ld,
  output logic [11:0]            o_rght_ld,
  output logic [11:0]            o_batt,
  output logic                   o_sum_gt_min,
  output logic                   o_sum_lt_min,
  output logic                   o_diff_gt_eigth,
  output logic                   o_diff_gt_15_16,
  output logic                   o_tmr_full,
  output logic                   o_cnv_err,
  output logic [1:0]             o_state
);

  localparam int SMP_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int TO_W  = (CNV_TIMEOUT > 1) ? $clog2(CNV_TIMEOUT) : 1;
  localparam logic [SMP_W-1:0] LP_SMP_LAST = SMP_W'(SAMPLE_PERIOD - 1);
  localparam logic [TO_W-1:0]  LP_TO_LAST  = TO_W'(CNV_TIMEOUT - 1);
  localparam logic [26:0]      LP_TMR_FULL = 27'(TMR_FULL_CNT);
  // MIN_RIDER_WT must be >= HYSTERESIS so the low threshold cannot wrap.
  localparam logic [12:0] LP_HI = {1'b0, MIN_RIDER_WT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] LP_LO = {1'b0, MIN_RIDER_WT} - {1'b0, HYSTERESIS};

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, STORE = 2'd3} state_t;

  state_t             r_state, w_state_nxt;
  logic [SMP_W-1:0]   r_smp_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [1:0]         r_idx;
  logic               r_pend;
  logic [11:0]        r_cap;
  logic               r_cap_vld;
  logic               r_flag_upd;
  logic [11:0]        r_lft_ld, r_rght_ld, r_batt;
  logic               r_sum_gt_min, r_sum_lt_min, r_diff_gt_eigth, r_diff_gt_15_16;
  logic               r_cnv_err;
  logic [26:0]        r_tmr;

  logic               w_tick;
  logic               w_strt, w_start_round, w_cap, w_tmo, w_idx_inc;
  logic               w_store_lft, w_store_rght, w_store_batt;
  logic [11:0]        w_lft_new, w_rght_new;
  logic [12:0]        w_sum, w_eighth, w_f16;
  logic [11:0]        w_diff;

  assign w_tick = (r_smp_cnt == LP_SMP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_strt        = 1'b0;
    w_start_round = 1'b0;
    w_cap         = 1'b0;
    w_tmo         = 1'b0;
    w_idx_inc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_tick || r_pend) begin
          w_start_round = 1'b1;
          w_state_nxt   = REQ;
        end
      end
      REQ: begin
        w_strt      = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (a2d.cnv_cmplt) begin
          w_cap       = 1'b1;
          w_state_nxt = STORE;
        end else if (r_to_cnt == LP_TO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = STORE;
        end
      end
      STORE: begin
        if (r_idx < 2'd2) begin
          w_idx_inc   = 1'b1;
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_store_lft  = (r_state == STORE) && r_cap_vld && (r_idx == 2'd0);
  assign w_store_rght = (r_state == STORE) && r_cap_vld && (r_idx == 2'd1);
  assign w_store_batt = (r_state == STORE) && r_cap_vld && (r_idx == 2'd2);

  // Sample tick, pending merge, channel index, timeout counter and captured result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp_cnt <= '0;
      r_pend    <= 1'b0;
      r_idx     <= 2'd0;
      r_to_cnt  <= '0;
      r_cap     <= 12'd0;
      r_cap_vld <= 1'b0;
      r_cnv_err <= 1'b0;
    end else begin
      r_smp_cnt <= w_tick ? '0 : r_smp_cnt + SMP_W'(1);
      if (w_start_round)  r_pend <= 1'b0;
      else if (w_tick)    r_pend <= 1'b1;
      if (w_start_round)  r_idx <= 2'd0;
      else if (w_idx_inc) r_idx <= r_idx + 2'd1;
      r_to_cnt <= (r_state == WAIT) ? r_to_cnt + TO_W'(1) : '0;
      if (w_cap) begin
        r_cap     <= a2d.res;
        r_cap_vld <= 1'b1;
      end else if (w_tmo) begin
        r_cap_vld <= 1'b0;
      end
      if (w_tmo) r_cnv_err <= 1'b1;
    end
  end

`ifdef LD_CELL_FILTER_EN
  logic        r_lft_seed, r_rght_seed;
  logic [13:0] w_lft_acc, w_rght_acc;

  assign w_lft_acc  = {1'b0, r_lft_ld, 1'b0} + {2'b00, r_lft_ld} + {2'b00, r_cap};
  assign w_rght_acc = {1'b0, r_rght_ld, 1'b0} + {2'b00, r_rght_ld} + {2'b00, r_cap};
  assign w_lft_new  = r_lft_seed  ? w_lft_acc[13:2]  : r_cap;
  assign w_rght_new = r_rght_seed ? w_rght_acc[13:2] : r_cap;

  // The first stored sample seeds the filter instead of being averaged with zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lft_seed  <= 1'b0;
      r_rght_seed <= 1'b0;
    end else begin
      if (w_store_lft)  r_lft_seed  <= 1'b1;
      if (w_store_rght) r_rght_seed <= 1'b1;
    end
  end
`else
  assign w_lft_new  = r_cap;
  assign w_rght_new = r_cap;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lft_ld  <= 12'd0;
      r_rght_ld <= 12'd0;
      r_batt    <= 12'd0;
    end else begin
      if (w_store_lft)  r_lft_ld  <= w_lft_new;
      if (w_store_rght) r_rght_ld <= w_rght_new;
      if (w_store_batt) r_batt    <= r_cap;
    end
  end

  assign w_sum    = {1'b0, r_lft_ld} + {1'b0, r_rght_ld};
  assign w_diff   = (r_lft_ld >= r_rght_ld) ? (r_lft_ld - r_rght_ld) : (r_rght_ld - r_lft_ld);
  assign w_eighth = w_sum >> 3;
  assign w_f16    = w_sum - (w_sum >> 4);

  // Flags follow the right-channel store only, so they always reflect a coherent left/right pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_upd      <= 1'b0;
      r_sum_gt_min    <= 1'b0;
      r_sum_lt_min    <= 1'b1;
      r_diff_gt_eigth <= 1'b0;
      r_diff_gt_15_16 <= 1'b0;
    end else begin
      r_flag_upd <= (r_state == STORE) && (r_idx == 2'd1);
      if (r_flag_upd) begin
        r_sum_gt_min    <= (w_sum > LP_HI);
        r_sum_lt_min    <= (w_sum < LP_LO);
        r_diff_gt_eigth <= ({1'b0, w_diff} > w_eighth);
        r_diff_gt_15_16 <= ({1'b0, w_diff} > w_f16);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_tmr <= 27'd0;
    else if (i_clr_tmr)            r_tmr <= 27'd0;
    else if (r_tmr != LP_TMR_FULL) r_tmr <= r_tmr + 27'd1;
  end

  assign a2d.strt_cnv    = w_strt;
  assign a2d.chnl        = (r_idx == 2'd0) ? 3'd0 : (r_idx == 2'd1) ? 3'd4 : 3'd5;
  assign o_lft_ld        = r_lft_ld;
  assign o_rght_ld       = r_rght_ld;
  assign o_batt          = r_batt;
  assign o_sum_gt_min    = r_sum_gt_min;
  assign o_sum_lt_min    = r_sum_lt_min;
  assign o_diff_gt_eigth = r_diff_gt_eigth;
  assign o_diff_gt_15_16 = r_diff_gt_15_16;
  assign o_tmr_full      = (r_tmr == LP_TMR_FULL);
  assign o_cnv_err       = r_cnv_err;
  assign o_state         = r_state;

endmodule
